// File: rtl/scroll_pkg.sv
// Shared symbol codes and the active-low 7-segment lookup (bit 0 = a ... bit 6 = g).
package scroll_pkg;

  localparam logic [3:0] SYM_BLANK = 4'hF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, SEG_OFF
  };

endpackage

// File: rtl/scroll_display_ctrl_sym_to_seg.sv
// Combinational symbol-to-segment decoder; the parent registers its output.
module sym_to_seg
  import scroll_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg_n
);

  always_comb seg_n = SEG_LUT[sym];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Multiplexed 7-segment scrolling message display: tick generation, digit scan,
// scroll offset and message buffer.
module scroll_display_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned SCAN_DIV   = 250000,
  parameter int unsigned SCROLL_DIV = 100000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       dir,
  input  logic                       step,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       wrap
);

  localparam int unsigned AW  = $clog2(MSG_LEN);
  localparam int unsigned DW  = $clog2(NUM_DIGITS);
  localparam int unsigned SCW = $clog2(SCAN_DIV + 1);
  localparam int unsigned SRW = $clog2(SCROLL_DIV + 1);

  localparam logic [SCW-1:0] SCAN_LAST   = SCW'(SCAN_DIV - 1);
  localparam logic [SRW-1:0] SCROLL_LAST = SRW'(SCROLL_DIV - 1);
  localparam logic [AW-1:0]  OFF_LAST    = AW'(MSG_LEN - 1);
  localparam logic [DW-1:0]  DIG_LAST    = DW'(NUM_DIGITS - 1);
  localparam logic [AW:0]    LEN_EXT     = (AW+1)'(MSG_LEN);
  localparam logic [AW:0]    SPAN_EXT    = (AW+1)'(NUM_DIGITS - 1);

  logic [1:0]            rst_sync_q;
  logic                  rst_n_int;
  logic [SCW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [SRW-1:0]        scroll_cnt_q, scroll_cnt_d;
  logic                  enable_q, enable_d;
  logic [AW-1:0]         offset_q, offset_d;
  logic                  wrap_q, wrap_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            msg_q [MSG_LEN];
  logic [3:0]            msg_d [MSG_LEN];

  logic                  scan_tick, scroll_tick, en_rise, advance, wr_ok;
  logic [AW:0]           idx_sum;
  logic [AW-1:0]         sym_idx;
  logic [3:0]            cur_sym;
  logic [6:0]            dec_seg;

  // Asynchronous assertion, release aligned to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Boot message 1,2,3,4 folded onto short buffers, blanks elsewhere.
  function automatic logic [3:0] init_sym(input int unsigned i);
    logic [3:0] s;
    s = SYM_BLANK;
    for (int unsigned k = 0; k < 4; k++)
      if (k % MSG_LEN == i) s = 4'(k + 1);
    return s;
  endfunction

  sym_to_seg u_dec (
    .sym   (cur_sym),
    .seg_n (dec_seg)
  );

  always_comb begin
    scan_tick    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + 1'b1;

    enable_d     = enable;
    en_rise      = enable & ~enable_q;
    scroll_tick  = (scroll_cnt_q == SCROLL_LAST) & ~en_rise;
    scroll_cnt_d = (en_rise || scroll_cnt_q == SCROLL_LAST) ? '0 : scroll_cnt_q + 1'b1;

    advance  = enable ? scroll_tick : step;
    offset_d = offset_q;
    wrap_d   = 1'b0;
    if (advance) begin
      if (!dir) begin
        if (offset_q == OFF_LAST) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + 1'b1;
        end
      end else begin
        if (offset_q == '0) begin
          offset_d = OFF_LAST;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q - 1'b1;
        end
      end
    end

    // Symbol shown on the digit currently selected; sum stays below 2*MSG_LEN.
    idx_sum = {1'b0, offset_q} + SPAN_EXT - (AW+1)'(dig_q);
    sym_idx = (idx_sum >= LEN_EXT) ? AW'(idx_sum - LEN_EXT) : AW'(idx_sum);
    cur_sym = msg_q[sym_idx];

    dig_d = dig_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (scan_tick) begin
      an_d  = ~(NUM_DIGITS'(1) << dig_q);
      seg_d = dec_seg;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end

    wr_ok = wr_en && ({1'b0, wr_addr} < LEN_EXT);
    msg_d = msg_q;
    if (wr_ok) msg_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      scan_cnt_q   <= '0;
      scroll_cnt_q <= '0;
      enable_q     <= 1'b0;
      offset_q     <= '0;
      wrap_q       <= 1'b0;
      dig_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= init_sym(i);
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      scroll_cnt_q <= scroll_cnt_d;
      enable_q     <= enable_d;
      offset_q     <= offset_d;
      wrap_q       <= wrap_d;
      dig_q        <= dig_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      msg_q        <= msg_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed bench for scroll_display_ctrl with a frame scoreboard (8- and 12-symbol buffers).
module tb_scroll_display_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       enable = 1'b0, dir = 1'b0, step = 1'b0, wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       wrap;

  logic       enable12 = 1'b0, dir12 = 1'b0, step12 = 1'b0, wr_en12 = 1'b0;
  logic [3:0] wr_addr12 = '0;
  logic [3:0] wr_data12 = '0;
  logic [6:0] seg12;
  logic [3:0] an12;
  logic       wrap12;

  scroll_display_ctrl #(.NUM_DIGITS(4), .MSG_LEN(8), .SCAN_DIV(4), .SCROLL_DIV(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seg(seg), .an(an), .wrap(wrap)
  );

  scroll_display_ctrl #(.NUM_DIGITS(4), .MSG_LEN(12), .SCAN_DIV(4), .SCROLL_DIV(16)) dut12 (
    .clk(clk), .reset(reset), .enable(enable12), .dir(dir12), .step(step12),
    .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
    .seg(seg12), .an(an12), .wrap(wrap12)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [27:0] segs;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  m8 [8];
  logic [3:0]  m12 [12];
  int unsigned off8, off12;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] s);
    case (s)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++)  m8[i]  = (i < 4) ? 4'(i + 1) : 4'hF;
    for (int i = 0; i < 12; i++) m12[i] = (i < 4) ? 4'(i + 1) : 4'hF;
    off8  = 0;
    off12 = 0;
  endtask

  // Digit d (0 = rightmost) shows msg[(offset + 3 - d) mod len].
  function automatic logic [27:0] model_frame(input bit w);
    logic [27:0] f;
    f = '0;
    for (int d = 0; d < 4; d++) begin
      if (w) f[7*d +: 7] = exp_seg(m12[(off12 + 3 - d) % 12]);
      else   f[7*d +: 7] = exp_seg(m8[(off8 + 3 - d) % 8]);
    end
    return f;
  endfunction

  task automatic expect_frame(input string tag, input bit w);
    exp_t e;
    e.tag  = tag;
    e.segs = model_frame(w);
    sb.push_back(e);
  endtask

  // Collect the next four scan updates (one per digit), bounded in cycles.
  task automatic capture(input bit w, output logic [27:0] got, output bit ok);
    logic [3:0] prev, cur;
    int seen, idx;
    got  = '1;
    ok   = 1'b1;
    seen = 0;
    @(negedge clk);
    prev = w ? an12 : an;
    for (int c = 0; c < 200 && seen < 4; c++) begin
      @(negedge clk);
      cur = w ? an12 : an;
      if (cur !== prev) begin
        prev = cur;
        idx  = -1;
        for (int i = 0; i < 4; i++) if (cur === ~(4'b0001 << i)) idx = i;
        if (idx < 0) ok = 1'b0;
        else got[7*idx +: 7] = w ? seg12 : seg;
        seen++;
      end
    end
    if (seen < 4) ok = 1'b0;
  endtask

  task automatic check_frame(input bit w);
    exp_t e;
    logic [27:0] got;
    bit ok;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    capture(w, got, ok);
    chk({e.tag, "_scan"}, ok, 1);
    chk(e.tag, got, e.segs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_an12", an12, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_step(input logic d, input bit exp_wrap);
    @(negedge clk);
    dir  = d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    off8 = d ? (off8 + 7) % 8 : (off8 + 1) % 8;
    chk("step_wrap_pulse", wrap, exp_wrap);
    @(negedge clk);
    chk("step_wrap_clear", wrap, 0);
  endtask

  initial begin
    int wcnt, wat;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_scan_an", an, 4'hF);
    expect_frame("first_frame", 0);
    check_frame(0);

    do_reset();
    expect_frame("after_midscan_reset", 0);
    check_frame(0);

    repeat (100) @(negedge clk);
    expect_frame("frozen_100", 0);
    check_frame(0);

    pulse_step(1'b0, 1'b0);
    expect_frame("step_left", 0);
    check_frame(0);

    @(negedge clk);
    enable = 1'b1;
    step   = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    expect_frame("step_while_enabled", 0);
    check_frame(0);

    pulse_step(1'b1, 1'b0);
    expect_frame("step_right_back", 0);
    check_frame(0);

    do_reset();
    pulse_step(1'b1, 1'b1);
    expect_frame("right_wrap", 0);
    check_frame(0);

    do_reset();
    @(negedge clk);
    dir = 1'b1; step = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
    @(negedge clk);
    step = 1'b0; wr_en = 1'b0;
    m8[0] = 4'h9;
    off8  = 7;
    chk("wr_adv_wrap", wrap, 1);
    expect_frame("write_during_advance", 0);
    check_frame(0);

    do_reset();
    @(negedge clk);
    enable = 1'b1; dir = 1'b0;
    repeat (17) @(posedge clk);
    #1 enable = 1'b0;
    off8 = 1;
    expect_frame("auto_left_first", 0);
    check_frame(0);

    do_reset();
    @(negedge clk);
    enable = 1'b1; dir = 1'b0;
    wcnt = 0; wat = -1;
    for (int c = 0; c <= 136; c++) begin
      @(posedge clk);
      #1;
      if (wrap) begin
        wcnt++;
        wat = c;
      end
    end
    enable = 1'b0;
    off8 = 0;
    chk("auto_wrap_count", wcnt, 1);
    chk("auto_wrap_cycle", wat, 128);
    expect_frame("auto_after_wrap", 0);
    check_frame(0);

    do_reset();
    @(negedge clk);
    wr_en12 = 1'b1; wr_addr12 = 4'd11; wr_data12 = 4'h0;
    @(negedge clk);
    wr_en12 = 1'b0;
    m12[11] = 4'h0;
    dir12 = 1'b1; step12 = 1'b1;
    @(negedge clk);
    step12 = 1'b0;
    off12 = 11;
    chk("len12_wrap", wrap12, 1);
    expect_frame("len12_right", 1);
    check_frame(1);

    @(negedge clk);
    wr_en12 = 1'b1; wr_addr12 = 4'd13; wr_data12 = 4'h5;
    @(negedge clk);
    wr_en12 = 1'b0;
    expect_frame("oob_write_ignored", 1);
    check_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
